// File: rtl/slice_seq_pkg.sv
// Shared constants and state encoding for the slice sequencer.
package slice_seq_pkg;
    localparam int N_DEF      = 25;
    localparam int SLICES_DEF = 64;
    localparam int CW_DEF     = 6;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_CAPTURE = 3'd2,
        S_PROCESS = 3'd3,
        S_EMIT    = 3'd4,
        S_DONE    = 3'd5
    } state_t;
endpackage

// File: rtl/slice_sequencer_index.sv
// Up/down slice index counter with load, enable and a direction-aware terminal flag.
module slice_index_counter
    import slice_seq_pkg::*;
#(
    parameter int SLICES = SLICES_DEF,
    parameter int CW     = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    input  logic          up,
    output logic [CW-1:0] idx,
    output logic          terminal
);
    always_ff @(posedge clk) begin
        if (rst)
            idx <= '0;
        else if (load)
            idx <= load_val;
        else if (en)
            idx <= up ? idx + 1'b1 : idx - 1'b1;
    end

    assign terminal = up ? (idx == CW'(SLICES - 1)) : (idx == '0);
endmodule

// File: rtl/slice_sequencer.sv
// Runs one encoder pass over SLICES lines: fetch, capture, process, emit per slice.
// Optional abort input/aborted pulse enabled by defining SLICE_SEQ_ABORT_EN.
module slice_sequencer
    import slice_seq_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int SLICES = SLICES_DEF,
    parameter int CW     = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          dir,
    input  logic [N-1:0]  rd_data,
    input  logic [N-1:0]  proc_data,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [CW-1:0] rd_addr,
    output logic          mux_sel,
    output logic [N-1:0]  line_q,
    output logic          out_valid,
    output logic [N-1:0]  out_line,
    output logic [CW-1:0] slice_idx
`ifdef SLICE_SEQ_ABORT_EN
    ,
    input  logic          abort,
    output logic          aborted
`endif
);
    state_t state, state_nx;
    logic   dir_q;
    logic   terminal;
    logic   idx_load;
    logic   idx_en;
    logic   xfer;
    logic   abort_hit;
    logic [N-1:0] line_d;

`ifdef SLICE_SEQ_ABORT_EN
    assign abort_hit = abort && (state != S_IDLE) && (state != S_DONE);

    always_ff @(posedge clk) begin
        if (rst)
            aborted <= 1'b0;
        else
            aborted <= abort_hit;
    end
`else
    assign abort_hit = 1'b0;
`endif

    assign xfer     = (state == S_EMIT) && out_ready;
    assign idx_load = (state == S_IDLE) && start;
    // The terminal check wins over the step, so the index never wraps.
    assign idx_en   = xfer && !terminal && !abort_hit;

    slice_index_counter #(
        .SLICES (SLICES),
        .CW     (CW)
    ) u_idx (
        .clk      (clk),
        .rst      (rst),
        .load     (idx_load),
        .load_val ((dir == DIR_UP) ? CW'(0) : CW'(SLICES - 1)),
        .en       (idx_en),
        .up       (dir_q),
        .idx      (slice_idx),
        .terminal (terminal)
    );

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (start) state_nx = S_FETCH;
            S_FETCH:   state_nx = S_CAPTURE;
            S_CAPTURE: state_nx = S_PROCESS;
            S_PROCESS: state_nx = S_EMIT;
            S_EMIT:    if (out_ready) state_nx = terminal ? S_DONE : S_FETCH;
            S_DONE:    state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
        if (abort_hit)
            state_nx = S_IDLE;
    end

    assign line_d = mux_sel ? proc_data : rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            dir_q  <= DIR_UP;
            line_q <= '0;
        end else begin
            state <= state_nx;
            if (idx_load)
                dir_q <= dir;
            if (!abort_hit && (state == S_CAPTURE || state == S_PROCESS))
                line_q <= line_d;
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign rd_en     = (state == S_FETCH);
    assign rd_addr   = slice_idx;
    assign mux_sel   = (state == S_PROCESS);
    assign out_valid = (state == S_EMIT);
    assign out_line  = line_q;
endmodule

// File: doc/slice_sequencer.md
Name: slice_sequencer

Overview:
Controller that runs one encoder pass over a state of SLICES lines, each N bits wide.
- Per slice: fetch from the synchronous line memory, capture into the line register, apply one encoder step through the feedback mux, then emit on a valid/ready sink.
- Sits between the state memory, the encoder combinational core and the output writer.
- Owns the slice index counter, the line register enable, the mux select and the output handshake.

Parameters:
N, 25, line width in bits.
SLICES, 64, slices per pass; must be ≥ 2.
CW, 6, index width; must satisfy 2**CW ≥ SLICES.

Ports:
clk  in  1  clock.
rst  in  1  reset: synchronous, active-high.
start  in  1  begin a pass; sampled only in IDLE.
dir  in  1  1 = ascending slice order, 0 = descending; captured at start.
rd_data  in  N  memory read data; valid the cycle after rd_en.
proc_data  in  N  encoder core output, combinational from line_q.
out_ready  in  1  sink ready.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse at pass completion.
rd_en  out  1  memory read strobe.
rd_addr  out  CW  slice index being read.
mux_sel  out  1  0 = load rd_data, 1 = load proc_data.
line_q  out  N  line register contents, to the encoder core.
out_valid  out  1  emitted line valid.
out_line  out  N  equals line_q while out_valid is high.
slice_idx  out  CW  index of the current slice.

Behaviour:
- Reset: state IDLE; busy, done, rd_en, mux_sel, out_valid = 0; line_q, slice_idx, rd_addr = 0. Reset mid-pass aborts immediately with no done.
- States: IDLE, FETCH, CAPTURE, PROCESS, EMIT, DONE.
- IDLE:
  - start=1 → FETCH.
  - slice_idx ← 0 if dir=1, else SLICES-1.
  - dir is latched; start while busy is ignored.
- FETCH: rd_en=1, rd_addr=slice_idx; → CAPTURE.
- CAPTURE: mux_sel=0, register loads rd_data at the edge; → PROCESS.
- PROCESS: mux_sel=1, register loads proc_data at the edge; → EMIT.
- EMIT:
  - out_valid=1, out_line=line_q, held stable until out_ready=1.
  - Transfer occurs on the edge where out_valid and out_ready are both 1.
  - If slice_idx is terminal (SLICES-1 ascending, 0 descending) → DONE.
  - Otherwise step slice_idx by ±1 and → FETCH.
- DONE: done=1 for one cycle; busy=1; → IDLE.
- Timing, out_ready tied high: 4 cycles per slice.
  - done is high in cycle 4·SLICES+1, counting the first FETCH cycle as cycle 1.
  - SLICES=64 gives cycle 257.
- Index arithmetic is modulo 2**CW but never wraps, because the terminal check precedes the step.
- start asserted in the same cycle as the DONE pulse is ignored; a new pass needs start in IDLE.
- The line register holds its value in IDLE, FETCH and EMIT.

Optional Feature:
SLICE_SEQ_ABORT_EN
- Defined:
  - Input abort (1 bit) and output aborted (1 bit, one-cycle pulse) exist.
  - abort=1 in any state other than IDLE/DONE → next state IDLE, aborted=1 for one cycle, no done, line_q keeps its value.
  - abort=1 in the same cycle as an EMIT handshake still aborts; that line counts as transferred.
- Undefined: neither port exists; behaviour is as above.

Decomposition:
- Package slice_seq_pkg: state enumeration constants (6 states, 3-bit encoding), default N/SLICES/CW, and the DIR_UP/DIR_DOWN constants.
- Sub-module slice_index_counter: up/down counter with load, enable and terminal flag, where terminal = (idx==SLICES-1 and up) or (idx==0 and down).
- The FSM, line register and mux stay in the top module.

Test Plan:
1. Ascending pass, SLICES=4, out_ready=1, memory[i]=i, proc_data=line_q^25'h1FFFFFF → out_line sequence 0x1FFFFFF, 0x1FFFFFE, 0x1FFFFFD, 0x1FFFFFC; done in cycle 17.
2. Descending pass, dir=0, SLICES=4 → rd_addr sequence 3, 2, 1, 0; done pulses exactly once.
3. Backpressure: out_ready=0 for 5 cycles during slice 1 → out_valid and out_line stable throughout; done delayed by exactly 5 cycles (cycle 22).
4. rst=1 in PROCESS of slice 2 → next cycle state IDLE, busy=0, line_q=0, no done; a subsequent start runs a full pass.
5. start pulsed while busy, and again in the DONE cycle → ignored; exactly one pass completes.
6. With SLICE_SEQ_ABORT_EN: abort in FETCH of slice 1 → aborted pulse, busy=0 next cycle, no done, exactly one line emitted.
